hazard_stall_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_detect.sv | 49 ++++
 rtl/hazard_stall_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the hazard stall unit.
//   state_t       : stall-controller FSM states
//   hazard_dbg_t  : debug snapshot exported by the top (FSM state + detector)
//   *_STALL       : stall lengths (cycles) for the hazard classes that
//                   forwarding cannot cover
//   REG_W_DEFAULT : default register-specifier width
//   sat_inc32     : saturating 32-bit increment used by the stall statistics
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_W_DEFAULT = 5;

    // Stall lengths, expressed as the number of bubble cycles required.
    localparam logic [1:0] NO_STALL          = 2'd0;
    localparam logic [1:0] LOAD_USE_STALL    = 2'd1;
    localparam logic [1:0] LOAD_BRANCH_STALL = 2'd2;
    localparam logic [1:0] ALU_BRANCH_STALL  = 2'd1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HOLD     = 2'd1,
        MEM_WAIT = 2'd2,
        TIMEOUT  = 2'd3
    } state_t;

    typedef struct packed {
        state_t     state;
        logic       match;
        logic [1:0] stall_n;
    } hazard_dbg_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational hazard classifier. Compares the EX destination against
// the ID source operands and reports how many stall cycles are needed.
// Ports:
//   id_rs, id_rt      : source specifiers of the ID instruction
//   id_uses_rt        : ID instruction actually reads RT
//   id_is_branch      : ID instruction is a branch comparing in ID
//   ex_mem_read       : EX instruction is a load
//   ex_reg_write      : EX instruction writes the register file
//   ex_dest           : destination specifier of the EX instruction
//   match             : EX destination feeds an ID source (r0 excluded)
//   stall_n           : required stall length in cycles (0, 1 or 2)
// -----------------------------------------------------------------------------
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT
)(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_dest,
    output logic             match,
    output logic [1:0]       stall_n
);

    // Register 0 is hard-wired to zero, so writing it never creates a hazard.
    assign match = (ex_dest != '0) &&
                   ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));

    // A load result is available only after MEM, so a branch comparing in ID
    // needs two bubbles; an ALU result reaching a branch in ID needs one.
    // ALU results feeding non-branch consumers are handled by forwarding.
    always_comb begin
        stall_n = NO_STALL;
        if (match) begin
            if (ex_mem_read) begin
                stall_n = id_is_branch ? LOAD_BRANCH_STALL : LOAD_USE_STALL;
            end else if (ex_reg_write && id_is_branch) begin
                stall_n = ALU_BRANCH_STALL;
            end
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Stall / flush / freeze controller that sits beside the ID stage.
// Handles hazards that forwarding cannot resolve by stalling PC and IF/ID and
// bubbling ID/EX, flushes IF/ID on taken branches, and freezes every pipeline
// register while a multi-cycle data-memory access is outstanding.
//
// Ports:
//   clk, reset                 : clock (rising edge), async active-high reset
//   id_rs, id_rt, id_uses_rt   : ID source operands
//   id_is_branch, branch_taken : ID branch info
//   ex_mem_read, ex_reg_write,
//   ex_dest                    : EX instruction write-back info
//   mem_req, mem_ready         : MEM-stage data-memory handshake
//   pc_write, ifid_write       : PC / IF-ID write enables
//   idex_bubble                : clear ID/EX control bits
//   ifid_flush                 : squash IF/ID instruction
//   pipe_freeze                : hold every pipeline register
//   mem_timeout                : sticky error, memory never became ready
//   stall_cycles               : stall statistics (0 unless stats enabled)
//   dbg                        : FSM state and detector results for checkers
//
// Memory handshake: an access is outstanding in every cycle where
// mem_req=1 and mem_ready=0; the cycle with mem_ready=1 completes it and is
// still a frozen cycle.
//
// Build option: define HAZARD_STALL_STATS_EN to build the saturating count of
// cycles with pc_write=0. Without it stall_cycles is constant zero.
// -----------------------------------------------------------------------------
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int REG_W        = REG_W_DEFAULT,
    parameter int MAX_MEM_WAIT = 15,
    parameter int CNT_W        = 4
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             branch_taken,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [31:0]      stall_cycles,
    output hazard_dbg_t      dbg
);

    localparam logic [CNT_W-1:0] MAX_WAIT = CNT_W'(MAX_MEM_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           r_ret_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_timeout;

    logic             w_match;
    logic [1:0]       w_stall_n;
    logic             w_mem_stall;
    logic             w_pc_write;
    logic             w_ifid_write;
    logic             w_idex_bubble;
    logic             w_ifid_flush;
    logic             w_pipe_freeze;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_is_branch (id_is_branch),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_dest      (ex_dest),
        .match        (w_match),
        .stall_n      (w_stall_n)
    );

    assign w_mem_stall = mem_req && !mem_ready;

    // Mealy output decode. Freeze has top priority, then hazard stalls, then
    // branch flush; a stall suppresses the flush because the branch has not
    // actually left ID yet.
    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_bubble = 1'b0;
        w_ifid_flush  = 1'b0;
        w_pipe_freeze = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_pipe_freeze = 1'b1;
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                end else if (w_stall_n != NO_STALL) begin
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                end else if (branch_taken) begin
                    w_ifid_flush  = 1'b1;
                end
            end
            HOLD: begin
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
                if (w_mem_stall) begin
                    w_pipe_freeze = 1'b1;
                end else begin
                    w_idex_bubble = 1'b1;
                end
            end
            MEM_WAIT, TIMEOUT: begin
                w_pipe_freeze = 1'b1;
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
            end
            default: begin
                w_pc_write   = 1'b1;
                w_ifid_write = 1'b1;
            end
        endcase
    end

    // Reset forces a free-running pipeline view regardless of inputs.
    assign pc_write    = reset ? 1'b1 : w_pc_write;
    assign ifid_write  = reset ? 1'b1 : w_ifid_write;
    assign idex_bubble = reset ? 1'b0 : w_idex_bubble;
    assign ifid_flush  = reset ? 1'b0 : w_ifid_flush;
    assign pipe_freeze = reset ? 1'b0 : w_pipe_freeze;
    assign mem_timeout = r_mem_timeout;

    assign dbg.state   = r_state;
    assign dbg.match   = w_match;
    assign dbg.stall_n = w_stall_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RUN;
            r_ret_state   <= RUN;
            r_hold_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state     <= MEM_WAIT;
                        r_wait_cnt  <= CNT_ONE;
                        r_ret_state <= RUN;
                    end else if (w_stall_n > 2'd1) begin
                        // The current cycle is the first bubble; HOLD covers
                        // the remaining ones.
                        r_state    <= HOLD;
                        r_hold_cnt <= CNT_W'(w_stall_n - 2'd1);
                    end
                end
                HOLD: begin
                    if (w_mem_stall) begin
                        // Remaining bubbles are kept for after the freeze.
                        r_state     <= MEM_WAIT;
                        r_wait_cnt  <= CNT_ONE;
                        r_ret_state <= HOLD;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - CNT_ONE;
                        if (r_hold_cnt <= CNT_ONE) begin
                            r_state <= RUN;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state    <= r_ret_state;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == MAX_WAIT) begin
                        r_mem_timeout <= 1'b1;
                        r_state       <= TIMEOUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_ONE;
                    end
                end
                TIMEOUT: begin
                    // Terminal until reset.
                    r_state <= TIMEOUT;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (!w_pc_write) begin
            r_stall_cycles <= sat_inc32(r_stall_cycles);
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
// Directed bench for hazard_stall_unit: a table of single-cycle vectors that
// keep the FSM in RUN, followed by hand-written multi-cycle sequences for the
// two-cycle stall, memory freeze (including freeze during HOLD), timeout and
// reset abort. Outputs are checked at the falling edge; inputs change 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;
    import hazard_pkg::*;

    // Expected output word: {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze}
    localparam logic [4:0] O_RUN    = 5'b11000;
    localparam logic [4:0] O_STALL  = 5'b00100;
    localparam logic [4:0] O_FLUSH  = 5'b11010;
    localparam logic [4:0] O_FREEZE = 5'b00001;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_dest;
    logic        id_uses_rt, id_is_branch, branch_taken;
    logic        ex_mem_read, ex_reg_write, mem_req, mem_ready;
    logic        pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze;
    logic        mem_timeout;
    logic [31:0] stall_cycles;
    hazard_dbg_t dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;

    hazard_stall_unit #(
        .REG_W(5), .MAX_MEM_WAIT(15), .CNT_W(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_is_branch (id_is_branch),
        .branch_taken (branch_taken),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_dest      (ex_dest),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
        .pipe_freeze  (pipe_freeze),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .dbg          (dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       uses_rt, is_br, taken, mrd, rwr;
        logic [4:0] dest;
        logic       mreq, mrdy;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input string name,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic uses_rt, input logic is_br,
                                input logic taken, input logic mrd,
                                input logic rwr, input logic [4:0] dest,
                                input logic mreq, input logic mrdy,
                                input logic [4:0] exp);
        vec_t v;
        v.name = name; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt;
        v.is_br = is_br; v.taken = taken; v.mrd = mrd; v.rwr = rwr;
        v.dest = dest; v.mreq = mreq; v.mrdy = mrdy; v.exp = exp;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                          input logic uses_rt, input logic is_br,
                          input logic taken, input logic mrd, input logic rwr,
                          input logic [4:0] dest, input logic mreq,
                          input logic mrdy);
        id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_is_branch = is_br;
        branch_taken = taken; ex_mem_read = mrd; ex_reg_write = rwr;
        ex_dest = dest; mem_req = mreq; mem_ready = mrdy;
    endtask

    task automatic set_idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Check outputs mid-cycle, then advance to just after the next rising edge.
    task automatic tick_chk(input string name, input logic [4:0] exp);
        @(negedge clk);
        chk(name, {27'd0, pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze},
            {27'd0, exp});
        if (exp[4] == 1'b0) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input state_t exp);
        chk(name, {30'd0, dbg.state}, {30'd0, exp});
    endtask

    task automatic chk_stats(input string name);
`ifdef HAZARD_STALL_STATS_EN
        chk(name, stall_cycles, exp_stall);
`else
        chk(name, stall_cycles, 32'd0);
`endif
    endtask

    // Asserts reset with hazard-provoking inputs to prove the outputs are forced.
    task automatic do_reset(input string name);
        set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk({name, "_outs"}, {27'd0, pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze},
            {27'd0, O_RUN});
        chk({name, "_timeout"}, {31'd0, mem_timeout}, 32'd0);
        chk_state({name, "_state"}, RUN);
        chk({name, "_stats"}, stall_cycles, 32'd0);
        exp_stall = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_idle();
    endtask

    // ---------------- test ----------------
    initial begin
        set_idle();
        reset = 1'b1;

        vecs[0]  = mk("idle",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);
        vecs[1]  = mk("load_use_rs",    8, 0, 0, 0, 0, 1, 0, 8, 0, 0, O_STALL);
        vecs[2]  = mk("load_use_rt",    3,12, 1, 0, 0, 1, 1,12, 0, 0, O_STALL);
        vecs[3]  = mk("load_rt_unused", 3,12, 0, 0, 0, 1, 1,12, 0, 0, O_RUN);
        vecs[4]  = mk("load_r0",        0, 0, 1, 0, 0, 1, 1, 0, 0, 0, O_RUN);
        vecs[5]  = mk("alu_branch",     5, 7, 1, 1, 0, 0, 1, 5, 0, 0, O_STALL);
        vecs[6]  = mk("alu_nonbranch",  5, 7, 1, 0, 0, 0, 1, 5, 0, 0, O_RUN);
        vecs[7]  = mk("branch_taken",   4, 6, 1, 1, 1, 0, 1, 9, 0, 0, O_FLUSH);
        vecs[8]  = mk("alu_br_taken",   6, 6, 1, 1, 1, 0, 1, 6, 0, 0, O_STALL);
        vecs[9]  = mk("load_use_taken", 8, 0, 0, 0, 1, 1, 0, 8, 0, 0, O_STALL);
        vecs[10] = mk("mem_ready_now",  1, 2, 1, 0, 0, 0, 0, 0, 1, 1, O_RUN);
        vecs[11] = mk("no_writer",      5, 5, 1, 1, 0, 0, 0, 5, 0, 0, O_RUN);

        @(posedge clk);
        #1;
        do_reset("reset_init");

        // Single-cycle table: none of these leave RUN.
        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].is_br,
                   vecs[i].taken, vecs[i].mrd, vecs[i].rwr, vecs[i].dest,
                   vecs[i].mreq, vecs[i].mrdy);
            tick_chk(vecs[i].name, vecs[i].exp);
            chk_state({vecs[i].name, "_state"}, RUN);
        end
        set_idle();
        tick_chk("table_after", O_RUN);
        chk_stats("stats_table");

        // Load-use: exactly one bubble then normal flow.
        set_in(8, 0, 0, 0, 0, 1, 0, 8, 0, 0);
        tick_chk("lu_c1", O_STALL);
        chk_state("lu_state", RUN);
        set_idle();
        tick_chk("lu_after", O_RUN);

        // Load feeding a branch via RT: two consecutive bubbles.
        set_in(1, 9, 1, 1, 0, 1, 0, 9, 0, 0);
        tick_chk("ldbr_c1", O_STALL);
        chk_state("ldbr_state1", HOLD);
        set_in(1, 9, 1, 1, 1, 0, 1, 9, 0, 0);   // ignored in HOLD
        tick_chk("ldbr_c2", O_STALL);
        chk_state("ldbr_state2", RUN);
        set_idle();
        tick_chk("ldbr_after", O_RUN);
        chk_stats("stats_ldbr");

        // Memory stall 3 cycles then ready; hazard+branch present but freeze wins.
        set_in(8, 0, 0, 0, 1, 1, 0, 8, 1, 0);
        tick_chk("mem_c1", O_FREEZE);
        chk_state("mem_state1", MEM_WAIT);
        tick_chk("mem_c2", O_FREEZE);
        tick_chk("mem_c3", O_FREEZE);
        set_in(8, 0, 0, 0, 1, 1, 0, 8, 1, 1);
        tick_chk("mem_c4_ready", O_FREEZE);
        chk_state("mem_state_ret", RUN);
        set_idle();
        tick_chk("mem_after", O_RUN);
        chk_stats("stats_mem");

        // Memory stall arriving during HOLD: remaining bubble resumes afterwards.
        set_in(1, 9, 1, 1, 0, 1, 0, 9, 0, 0);
        tick_chk("hm_c1", O_STALL);
        chk_state("hm_hold", HOLD);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick_chk("hm_freeze1", O_FREEZE);
        chk_state("hm_wait", MEM_WAIT);
        tick_chk("hm_freeze2", O_FREEZE);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick_chk("hm_freeze3", O_FREEZE);
        chk_state("hm_back_hold", HOLD);
        set_idle();
        tick_chk("hm_resume", O_STALL);
        chk_state("hm_run", RUN);
        tick_chk("hm_after", O_RUN);
        chk_stats("stats_hold_mem");

        // Reset in the middle of HOLD aborts with no residual stall.
        set_in(1, 9, 1, 1, 0, 1, 0, 9, 0, 0);
        tick_chk("rh_c1", O_STALL);
        chk_state("rh_hold", HOLD);
        do_reset("reset_hold");
        tick_chk("rh_after", O_RUN);

        // Memory never ready: timeout after 15 wait cycles, then sticky.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            chk("to_not_yet", {31'd0, mem_timeout}, 32'd0);
            tick_chk("to_freeze", O_FREEZE);
        end
        chk("to_set", {31'd0, mem_timeout}, 32'd1);
        chk_state("to_state", TIMEOUT);
        set_in(8, 0, 0, 0, 1, 1, 0, 8, 0, 1);
        tick_chk("to_hold1", O_FREEZE);
        tick_chk("to_hold2", O_FREEZE);
        chk("to_sticky", {31'd0, mem_timeout}, 32'd1);
        chk_state("to_state_sticky", TIMEOUT);
        chk_stats("stats_timeout");
        do_reset("reset_timeout");
        tick_chk("to_after", O_RUN);
        chk_stats("stats_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so a wedged run still ends with a report.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
